// File: rtl/scanner_pkg.sv
// Scanner serial link shared definitions.
// Used by both the transmitter and receiver ends.
package scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RECV  = 2'b01,
        STORE = 2'b10
    } state_t;

    localparam int WORD_BITS_DEF = 4;

endpackage

// File: rtl/scanner_fifo.sv
// Small synchronous FIFO for received scanner words.
// A pop on empty is ignored; a push on full succeeds only with a pop.
module scanner_fifo
    import scanner_pkg::*;
#(
    parameter int W     = WORD_BITS_DEF,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_din,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rd];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/scanner_receiver.sv
// Receive end of the scanner serial link.
// Syncs clkIn/dataIn, assembles MSB-first words, buffers them in a FIFO.
module scanner_receiver
    import scanner_pkg::*;
#(
    parameter int WORD_BITS  = WORD_BITS_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkIn,
    input  logic                 dataIn,
    output logic                 readyForTransferOut,
    output logic [WORD_BITS-1:0] wordOut,
    output logic                 wordValid,
    input  logic                 wordTaken,
    output logic                 overflow,
    output logic                 frameError,
    output logic [1:0]           ps,
    output logic [2:0]           bitCount
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);

    logic r_clk_s1;
    logic r_clk_s2;
    logic r_clk_s3;
    logic r_dat_s1;
    logic r_dat_s2;

    state_t               r_state;
    logic [WORD_BITS-1:0] r_shift;
    logic [2:0]           r_bits;
    logic [TW-1:0]        r_tmo;
    logic                 r_ferr;
    logic                 r_ovf;

    logic          w_edge;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    assign w_edge = r_clk_s2 & ~r_clk_s3;
    assign w_push = (r_state == STORE);
    assign w_pop  = wordTaken & ~w_empty;

    assign readyForTransferOut = (w_count != CW'(FIFO_DEPTH));
    assign wordValid           = ~w_empty;
    assign overflow            = r_ovf;
    assign frameError          = r_ferr;
    assign ps                  = r_state;
    assign bitCount            = r_bits;

    // Two-flop synchronizers plus an extra clkIn flop for edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b0;
            r_clk_s2 <= 1'b0;
            r_clk_s3 <= 1'b0;
            r_dat_s1 <= 1'b0;
            r_dat_s2 <= 1'b0;
        end else begin
            r_clk_s1 <= clkIn;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= dataIn;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Word assembly FSM with inter-bit timeout and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bits  <= '0;
            r_tmo   <= '0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            case (r_state)
                RECV: begin
                    if (w_edge) begin
                        r_shift <= {r_shift[WORD_BITS-2:0], r_dat_s2};
                        r_bits  <= r_bits + 3'd1;
                        r_tmo   <= '0;
                        if (r_bits + 3'd1 == 3'(WORD_BITS)) begin
                            r_state <= STORE;
                        end
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_ferr  <= 1'b1;
                        r_shift <= '0;
                        r_bits  <= '0;
                        r_tmo   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                STORE: begin
                    if (w_full && !w_pop) begin
                        r_ovf <= 1'b1;
                    end
                    r_bits  <= '0;
                    r_tmo   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_bits <= '0;
                    r_tmo  <= '0;
                    if (w_edge) begin
                        r_shift <= {{(WORD_BITS-1){1'b0}}, r_dat_s2};
                        r_bits  <= 3'd1;
                        r_state <= RECV;
                    end
                end
            endcase
        end
    end

    scanner_fifo #(
        .W     (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_shift),
        .o_dout  (wordOut),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_scanner_receiver.sv
// Directed bench for scanner_receiver.
// Drives the serial pair at 8 clk per bit and checks words/flags.
module tb_scanner_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkIn;
    logic       dataIn;
    logic       readyForTransferOut;
    logic [3:0] wordOut;
    logic       wordValid;
    logic       wordTaken;
    logic       overflow;
    logic       frameError;
    logic [1:0] ps;
    logic [2:0] bitCount;

    int n_chk = 0;
    int n_err = 0;

    scanner_receiver dut (
        .clk                 (clk),
        .rst                 (rst),
        .clkIn               (clkIn),
        .dataIn              (dataIn),
        .readyForTransferOut (readyForTransferOut),
        .wordOut             (wordOut),
        .wordValid           (wordValid),
        .wordTaken           (wordTaken),
        .overflow            (overflow),
        .frameError          (frameError),
        .ps                  (ps),
        .bitCount            (bitCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        clkIn  = 1'b0;
        dataIn = b;
        cyc(4);
        clkIn = 1'b1;
        cyc(4);
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i]);
        end
        clkIn = 1'b0;
        cyc(8);
    endtask

    task automatic pop_chk(input string tag, input logic [3:0] exp);
        chk(tag, wordOut, exp);
        wordTaken = 1'b1;
        cyc(1);
        wordTaken = 1'b0;
    endtask

    initial begin
        int pulses;
        logic got_store;
        rst       = 1'b0;
        clkIn     = 1'b0;
        dataIn    = 1'b0;
        wordTaken = 1'b0;
        cyc(2);

        chk("rst_ready", readyForTransferOut, 1);
        chk("rst_valid", wordValid, 0);
        chk("rst_word", wordOut, 0);
        chk("rst_ps", ps, 0);
        chk("rst_bits", bitCount, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frameError, 0);
        rst = 1'b1;
        cyc(2);

        // Word 0101 with latency check on the last rise.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t1_bits3", bitCount, 3);
        clkIn  = 1'b0;
        dataIn = 1'b1;
        cyc(4);
        clkIn = 1'b1;
        cyc(2);
        chk("t1_valid_early", wordValid, 0);
        cyc(2);
        chk("t1_valid", wordValid, 1);
        chk("t1_word", wordOut, 4'b0101);
        cyc(4);
        clkIn = 1'b0;
        cyc(8);
        pop_chk("t1_pop", 4'b0101);
        chk("t1_empty", wordValid, 0);

        // Five words without pops: fill then overflow.
        for (int i = 1; i <= 4; i++) begin
            send_word(4'(i));
        end
        chk("t2_ready_full", readyForTransferOut, 0);
        chk("t2_ovf_before", overflow, 0);
        send_word(4'b0101);
        chk("t2_ovf", overflow, 1);
        pop_chk("t2_pop1", 4'b0001);
        chk("t2_ready", readyForTransferOut, 1);
        pop_chk("t2_pop2", 4'b0010);
        pop_chk("t2_pop3", 4'b0011);
        pop_chk("t2_pop4", 4'b0100);
        chk("t2_empty", wordValid, 0);

        // Two bits then a long stall: timeout aborts the word.
        send_bit(1'b1);
        send_bit(1'b1);
        clkIn  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            if (frameError) pulses++;
            cyc(1);
        end
        chk("t3_ferr_pulses", pulses, 1);
        chk("t3_ps", ps, 0);
        chk("t3_nopush", wordValid, 0);
        send_word(4'b1010);
        pop_chk("t3_word", 4'b1010);

        // Reset mid-word clears everything without a frame error.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t5_bits3", bitCount, 3);
        clkIn = 1'b0;
        rst   = 1'b0;
        #2;
        chk("t5_ps", ps, 0);
        chk("t5_bits", bitCount, 0);
        chk("t5_valid", wordValid, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_ready", readyForTransferOut, 1);
        cyc(2);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            if (frameError) pulses++;
            cyc(1);
        end
        chk("t5_no_ferr", pulses, 0);
        send_word(4'b1100);
        pop_chk("t5_word", 4'b1100);

        // Full FIFO, pop coincides with the fifth word's store.
        send_word(4'b0110);
        send_word(4'b0111);
        send_word(4'b1000);
        send_word(4'b1001);
        chk("t4_full", readyForTransferOut, 0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        clkIn  = 1'b0;
        dataIn = 1'b0;
        cyc(4);
        clkIn     = 1'b1;
        got_store = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (ps == 2'b10) begin
                got_store = 1'b1;
                break;
            end
        end
        chk("t4_store_seen", got_store, 1);
        wordTaken = 1'b1;
        cyc(1);
        wordTaken = 1'b0;
        chk("t4_ovf", overflow, 0);
        chk("t4_still_full", readyForTransferOut, 0);
        cyc(4);
        clkIn = 1'b0;
        cyc(8);
        pop_chk("t4_pop1", 4'b0111);
        pop_chk("t4_pop2", 4'b1000);
        pop_chk("t4_pop3", 4'b1001);
        pop_chk("t4_pop4", 4'b1010);
        chk("t4_empty", wordValid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
